// File: rtl/mem_stage_ctrl.sv
// Multi-cycle MIPS memory stage: issues registered req/ack bus accesses, formats loads,
// raises alignment/timeout exceptions, and stalls upstream until each access completes.
module mem_stage_ctrl #(
  parameter logic [31:0] IRAM_BASE  = 32'h8000_0000,
  parameter logic [31:0] IRAM_LIMIT = 32'h8040_0000,
  parameter int          TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  memop_i,
  input  logic [31:0] maddr_i,
  input  logic [31:0] reg2_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [1:0]  exc_o,
  output logic [31:0] exc_addr_o,
  output logic        iram_conflict_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic { S_IDLE = 1'b0, S_BUSY = 1'b1 } state_e;
  typedef enum logic [1:0] { SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2 } size_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   maddr_q, maddr_d;
  logic [4:0]    lwd_q, lwd_d;
  logic          lwreg_q, lwreg_d;

  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [3:0]    bus_sel_q, bus_sel_d;
  logic          wb_valid_q, wb_valid_d;
  logic [4:0]    wd_q, wd_d;
  logic          wreg_q, wreg_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    exc_q, exc_d;
  logic [31:0]   exc_addr_q, exc_addr_d;
  logic          iram_q, iram_d;

  logic          in_load, in_store, in_mem, misalign;
  size_e         in_sz;
  logic [3:0]    in_sel;
  logic [31:0]   in_wdata;
  logic [31:0]   rd_shift, ld_data;

  always_comb begin
    in_load  = 1'b0;
    in_store = 1'b0;
    in_sz    = SZ_B;
    case (memop_i)
      4'd1, 4'd2: in_load = 1'b1;
      4'd3, 4'd4: begin in_load = 1'b1; in_sz = SZ_H; end
      4'd5:       begin in_load = 1'b1; in_sz = SZ_W; end
      4'd6:       in_store = 1'b1;
      4'd7:       begin in_store = 1'b1; in_sz = SZ_H; end
      4'd8:       begin in_store = 1'b1; in_sz = SZ_W; end
      default: ;
    endcase
  end

  assign in_mem   = in_load | in_store;
  assign misalign = ((in_sz == SZ_H) && maddr_i[0]) || ((in_sz == SZ_W) && (|maddr_i[1:0]));

  always_comb begin
    in_sel   = 4'hF;
    in_wdata = reg2_i;
    case (in_sz)
      SZ_B: begin
        in_sel   = 4'b0001 << maddr_i[1:0];
        in_wdata = {24'b0, reg2_i[7:0]} << {maddr_i[1:0], 3'b000};
      end
      SZ_H: begin
        in_sel   = maddr_i[1] ? 4'b1100 : 4'b0011;
        in_wdata = maddr_i[1] ? {reg2_i[15:0], 16'b0} : {16'b0, reg2_i[15:0]};
      end
      default: ;
    endcase
  end

  // Load lane extraction uses the offset latched at issue, not the live address.
  assign rd_shift = bus_rdata_i >> {off_q, 3'b000};
  always_comb begin
    case (op_q)
      4'd1:    ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      4'd2:    ld_data = {24'b0, rd_shift[7:0]};
      4'd3:    ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      4'd4:    ld_data = {16'b0, rd_shift[15:0]};
      default: ld_data = bus_rdata_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    off_d       = off_q;
    maddr_d     = maddr_q;
    lwd_d       = lwd_q;
    lwreg_d     = lwreg_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    wb_valid_d  = 1'b0;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    exc_d       = 2'b00;
    exc_addr_d  = exc_addr_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          if (!in_mem) begin
            wb_valid_d = 1'b1;
            wd_d       = wd_i;
            wreg_d     = wreg_i;
            wdata_d    = wdata_i;
          end else if (misalign) begin
            wb_valid_d = 1'b1;
            wd_d       = wd_i;
            wreg_d     = 1'b0;
            wdata_d    = 32'b0;
            exc_d      = in_load ? 2'b01 : 2'b10;
            exc_addr_d = maddr_i;
          end else begin
            state_d     = S_BUSY;
            cnt_d       = '0;
            op_d        = memop_i;
            off_d       = maddr_i[1:0];
            maddr_d     = maddr_i;
            lwd_d       = wd_i;
            lwreg_d     = wreg_i;
            bus_req_d   = 1'b1;
            bus_we_d    = in_store;
            bus_addr_d  = {maddr_i[31:2], 2'b00};
            bus_sel_d   = in_sel;
            bus_wdata_d = in_wdata;
          end
        end
      end
      S_BUSY: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus_ack_i) begin
          state_d    = S_IDLE;
          bus_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wd_d       = lwd_q;
          wreg_d     = !bus_we_q && lwreg_q;
          wdata_d    = bus_we_q ? 32'b0 : ld_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = S_IDLE;
          bus_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wd_d       = lwd_q;
          wreg_d     = 1'b0;
          wdata_d    = 32'b0;
          exc_d      = 2'b11;
          exc_addr_d = maddr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    iram_d = bus_req_d && (bus_addr_d >= IRAM_BASE) && (bus_addr_d < IRAM_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= 4'b0;
      off_q       <= 2'b0;
      maddr_q     <= 32'b0;
      lwd_q       <= 5'b0;
      lwreg_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'b0;
      bus_wdata_q <= 32'b0;
      bus_sel_q   <= 4'b0;
      wb_valid_q  <= 1'b0;
      wd_q        <= 5'b0;
      wreg_q      <= 1'b0;
      wdata_q     <= 32'b0;
      exc_q       <= 2'b0;
      exc_addr_q  <= 32'b0;
      iram_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      off_q       <= off_d;
      maddr_q     <= maddr_d;
      lwd_q       <= lwd_d;
      lwreg_q     <= lwreg_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      wb_valid_q  <= wb_valid_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      exc_q       <= exc_d;
      exc_addr_q  <= exc_addr_d;
      iram_q      <= iram_d;
    end
  end

  // Stall drops in the ack cycle and in the final timeout cycle so upstream advances on that edge.
  assign stall_o = !rst && ((state_q == S_BUSY) ? (!bus_ack_i && (cnt_q != CNT_LAST))
                                                 : (valid_i && in_mem && !misalign));

  assign bus_req_o       = bus_req_q;
  assign bus_we_o        = bus_we_q;
  assign bus_addr_o      = bus_addr_q;
  assign bus_wdata_o     = bus_wdata_q;
  assign bus_sel_o       = bus_sel_q;
  assign wb_valid_o      = wb_valid_q;
  assign wd_o            = wd_q;
  assign wreg_o          = wreg_q;
  assign wdata_o         = wdata_q;
  assign exc_o           = exc_q;
  assign exc_addr_o      = exc_addr_q;
  assign iram_conflict_o = iram_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: directed cases plus randomized ops against a transaction-level model.
module tb_mem_stage_ctrl;
  localparam int TO = 16;
  localparam logic [31:0] IB = 32'h8000_0000;
  localparam logic [31:0] IL = 32'h8040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, wreg_i, bus_ack_i;
  logic [4:0]  wd_i;
  logic [31:0] wdata_i, maddr_i, reg2_i, bus_rdata_i;
  logic [3:0]  memop_i;
  logic        bus_req_o, bus_we_o, stall_o, wb_valid_o, wreg_o, iram_conflict_o;
  logic [31:0] bus_addr_o, bus_wdata_o, wdata_o, exc_addr_o;
  logic [3:0]  bus_sel_o;
  logic [4:0]  wd_o;
  logic [1:0]  exc_o;

  int n_tests = 0, n_fail = 0, wb_seen = 0, wb_exp = 0;

  mem_stage_ctrl #(.IRAM_BASE(IB), .IRAM_LIMIT(IL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .memop_i(memop_i), .maddr_i(maddr_i), .reg2_i(reg2_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wd_o(wd_o),
    .wreg_o(wreg_o), .wdata_o(wdata_o), .exc_o(exc_o), .exc_addr_o(exc_addr_o),
    .iram_conflict_o(iram_conflict_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wb_valid_o) wb_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Access size in bytes; 0 means not a memory op.
  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input int off, input logic [31:0] rd);
    int sz = op_size(op);
    logic [31:0] v = rd >> (8 * off);
    if (sz == 1) begin
      v = v % 256;
      if (op == 4'd1 && v >= 128) v = v - 256;
    end else if (sz == 2) begin
      v = v % 65536;
      if (op == 4'd3 && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_store(input int sz, input int off, input logic [31:0] r2);
    logic [31:0] m = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    return (r2 & m) << (8 * off);
  endfunction

  task automatic idle_cycle(input bit stray_ack);
    valid_i   = 1'b0;
    bus_ack_i = stray_ack;
    #1;
    chk("idle_stall", 32'(stall_o), 0);
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    chk("idle_req", 32'(bus_req_o), 0);
    chk("idle_wb", 32'(wb_valid_o), 0);
  endtask

  // dly = number of BUSY cycles without ack before the ack; dly >= TO never acks.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] r2,
                       input logic [4:0] wd, input logic wr, input logic [31:0] alu,
                       input int dly, input logic [31:0] rd);
    int  sz  = op_size(op);
    bit  ld  = (op >= 4'd1 && op <= 4'd5);
    int  off = int'(addr[1:0]);
    bit  mis = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
    logic [31:0] wa = {addr[31:2], 2'b00};
    int  stalls = 1;
    bit  done = 0;
    valid_i = 1'b1; memop_i = op; maddr_i = addr; reg2_i = r2;
    wd_i = wd; wreg_i = wr; wdata_i = alu;
    #1;
    if (sz == 0) begin
      chk("nop_stall", 32'(stall_o), 0);
      @(posedge clk); #1;
      valid_i = 1'b0;
      chk("nop_wb", 32'(wb_valid_o), 1);
      chk("nop_wd", 32'(wd_o), 32'(wd));
      chk("nop_wreg", 32'(wreg_o), 32'(wr));
      chk("nop_wdata", wdata_o, alu);
      chk("nop_exc", 32'(exc_o), 0);
      chk("nop_req", 32'(bus_req_o), 0);
      wb_exp++;
    end else if (mis) begin
      chk("mis_stall", 32'(stall_o), 0);
      @(posedge clk); #1;
      valid_i = 1'b0;
      chk("mis_exc", 32'(exc_o), ld ? 1 : 2);
      chk("mis_addr", exc_addr_o, addr);
      chk("mis_wb", 32'(wb_valid_o), 1);
      chk("mis_wreg", 32'(wreg_o), 0);
      chk("mis_req", 32'(bus_req_o), 0);
      wb_exp++;
    end else begin
      chk("iss_stall", 32'(stall_o), 1);
      @(posedge clk); #1;
      chk("iss_req", 32'(bus_req_o), 1);
      chk("iss_we", 32'(bus_we_o), ld ? 0 : 1);
      chk("iss_addr", bus_addr_o, wa);
      chk("iss_sel", 32'(bus_sel_o), ((1 << sz) - 1) << off);
      if (!ld) chk("iss_wdata", bus_wdata_o, exp_store(sz, off, r2));
      chk("iss_iram", 32'(iram_conflict_o), (wa >= IB && wa < IL) ? 1 : 0);
      chk("iss_wb", 32'(wb_valid_o), 0);
      for (int k = 0; k < TO && !done; k++) begin
        bus_rdata_i = $urandom;
        if (k == dly) begin bus_ack_i = 1'b1; bus_rdata_i = rd; end
        #1;
        if (stall_o) stalls++;
        chk("busy_req", 32'(bus_req_o), 1);
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
        if (k == dly) done = 1;
      end
      valid_i = 1'b0;
      chk("end_req", 32'(bus_req_o), 0);
      chk("end_iram", 32'(iram_conflict_o), 0);
      chk("end_wb", 32'(wb_valid_o), 1);
      chk("end_stalls", stalls, (dly < TO) ? dly + 1 : TO);
      if (dly < TO) begin
        chk("end_exc", 32'(exc_o), 0);
        chk("end_wd", 32'(wd_o), 32'(wd));
        chk("end_wreg", 32'(wreg_o), ld ? 32'(wr) : 0);
        if (ld) chk("end_ldata", wdata_o, exp_load(op, off, rd));
      end else begin
        chk("to_exc", 32'(exc_o), 3);
        chk("to_addr", exc_addr_o, addr);
        chk("to_wreg", 32'(wreg_o), 0);
      end
      wb_exp++;
    end
  endtask

  initial begin
    logic [31:0] a;
    int r, d;
    rst = 1'b1; valid_i = 1'b0; memop_i = 4'd0; maddr_i = 32'b0; reg2_i = 32'b0;
    wd_i = 5'b0; wreg_i = 1'b0; wdata_i = 32'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus_req_o), 0);
    chk("rst_sel", 32'(bus_sel_o), 0);
    chk("rst_wb", 32'(wb_valid_o), 0);
    chk("rst_exc", 32'(exc_o), 0);
    chk("rst_exc_addr", exc_addr_o, 0);
    chk("rst_stall", 32'(stall_o), 0);
    rst = 1'b0;

    do_op(4'd1, 32'h8000_0003, 32'h0, 5'd3, 1'b1, 32'h0, 0, 32'h8512_3456);
    do_op(4'd2, 32'h8000_0003, 32'h0, 5'd4, 1'b1, 32'h0, 1, 32'h8512_3456);
    do_op(4'd7, 32'h8040_0002, 32'h1234_ABCD, 5'd5, 1'b1, 32'h0, 0, 32'h0);
    do_op(4'd5, 32'h8040_0001, 32'h0, 5'd6, 1'b1, 32'h0, 0, 32'h0);
    do_op(4'd8, 32'h8040_0002, 32'h0, 5'd7, 1'b1, 32'h0, 0, 32'h0);
    do_op(4'd5, 32'h0000_1000, 32'h0, 5'd8, 1'b1, 32'h0, 3, 32'hDEAD_BEEF);
    do_op(4'd6, 32'h0000_2001, 32'h0000_00A5, 5'd9, 1'b0, 32'h0, 0, 32'h0);
    do_op(4'd6, 32'h0000_2002, 32'h0000_005A, 5'd9, 1'b0, 32'h0, 0, 32'h0);
    do_op(4'd5, 32'h8000_0100, 32'h0, 5'd10, 1'b1, 32'h0, 99, 32'h0);
    do_op(4'd5, 32'h8000_0104, 32'h0, 5'd11, 1'b1, 32'h0, TO - 1, 32'hCAFE_F00D);
    do_op(4'd0, 32'h0, 32'h0, 5'd12, 1'b1, 32'h1357_9BDF, 0, 32'h0);
    idle_cycle(1'b1);

    // Reset while BUSY, after a misalignment has left exc_addr_o non-zero.
    do_op(4'd3, 32'h0000_3003, 32'h0, 5'd1, 1'b1, 32'h0, 0, 32'h0);
    valid_i = 1'b1; memop_i = 4'd5; maddr_i = 32'h8000_0010; wd_i = 5'd2; wreg_i = 1'b1;
    @(posedge clk); #1;
    chk("rb_req", 32'(bus_req_o), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rb_req0", 32'(bus_req_o), 0);
    chk("rb_sel0", 32'(bus_sel_o), 0);
    chk("rb_addr0", bus_addr_o, 0);
    chk("rb_exc_addr0", exc_addr_o, 0);
    chk("rb_iram0", 32'(iram_conflict_o), 0);
    chk("rb_stall0", 32'(stall_o), 0);
    rst = 1'b0; valid_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_1111;
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    chk("rb_stray_wb", 32'(wb_valid_o), 0);
    chk("rb_stray_req", 32'(bus_req_o), 0);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0:       a = IB + $urandom_range(0, 255);
        1:       a = IL - 32'd16 + $urandom_range(0, 31);
        2:       a = 32'h7FFF_FFF8 + $urandom_range(0, 15);
        default: a = $urandom;
      endcase
      r = $urandom_range(0, 9);
      d = (r < 7) ? $urandom_range(0, 4) : (r == 7) ? TO - 1 : (r == 8) ? TO : TO + 5;
      do_op(4'($urandom_range(0, 15)), a, $urandom, 5'($urandom), 1'($urandom), $urandom, d, $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
    end

    @(posedge clk); #1;
    chk("wb_pulse_count", wb_seen, wb_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Multi-cycle MIPS memory-access stage that replaces the combinational load/store path. It issues registered requests on a req/ack data bus and supports byte, halfword and word loads and stores, with signed and unsigned loads. It formats load data, raises alignment and bus-timeout exceptions, and stalls the pipeline until each access completes. It sits between the EX/MEM pipeline register and write-back, and flags instruction-RAM conflicts to the fetch arbiter.

Parameters:
IRAM_BASE, 32'h80000000, inclusive lower bound of the instruction-RAM address window
IRAM_LIMIT, 32'h80400000, exclusive upper bound of the instruction-RAM address window
TIMEOUT, 16, number of BUSY cycles without bus_ack_i before the access is aborted (must be ≥1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
valid_i  in  1  EX/MEM holds a valid instruction
wd_i  in  5  destination register
wreg_i  in  1  register write enable
wdata_i  in  32  ALU result, used for non-load instructions
memop_i  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; any other value is treated as none
maddr_i  in  32  effective address
reg2_i  in  32  store source data
bus_req_o  out  1  bus request
bus_we_o  out  1  bus write
bus_addr_o  out  32  word-aligned address ({maddr[31:2],2'b00})
bus_wdata_o  out  32  lane-shifted store data
bus_sel_o  out  4  byte enables
bus_ack_i  in  1  one-cycle completion strobe
bus_rdata_i  in  32  read data, valid when bus_ack_i is high
stall_o  out  1  hold EX/MEM and upstream stages
wb_valid_o  out  1  write-back slot valid (1-cycle pulse)
wd_o  out  5  write-back register
wreg_o  out  1  write-back enable
wdata_o  out  32  write-back data
exc_o  out  2  00 none, 01 misaligned load, 10 misaligned store, 11 bus timeout (1-cycle pulse)
exc_addr_o  out  32  faulting maddr_i
iram_conflict_o  out  1  high while bus_req_o is high and bus_addr_o is within [IRAM_BASE, IRAM_LIMIT)

Behaviour:
- Reset: state IDLE; every output 0, including bus_sel_o=0 and exc_addr_o=0; timeout counter cleared. Reset mid-access drops bus_req_o at the same edge. A late bus_ack_i arriving after that edge is ignored.
- All outputs are registered, except stall_o, which is combinational.
- Alignment rules: halfword accesses need maddr[0]=0; word accesses need maddr[1:0]=0.
- IDLE, valid_i high, memop none:
  - Next edge: wb_valid_o=1; wd_o, wreg_o, wdata_o taken from the inputs.
  - stall_o=0. Latency 1 cycle.
- IDLE, valid_i high, misaligned access:
  - No bus request.
  - Next edge: exc_o=01 for a load or 10 for a store, exc_addr_o=maddr_i, wb_valid_o=1 with wreg_o=0.
  - stall_o=0.
- IDLE, valid_i high, aligned access:
  - stall_o=1.
  - Next edge: latch op, wd, wreg, byte offset; drive bus_req_o=1, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o; go to BUSY.
- Byte enables: byte access sel=4'b0001<<maddr[1:0]; halfword sel=4'b0011 at offset 0, 4'b1100 at offset 2; word sel=4'b1111.
- Store data: SB replicates the byte into its lane only, other lanes 0. SH places the halfword in its lane, other lanes 0. SW passes reg2_i unchanged.
- BUSY:
  - Bus outputs are held stable.
  - stall_o = !bus_ack_i, so upstream advances on the ack edge.
  - On bus_ack_i: bus_req_o drops at the same edge, wb_valid_o=1, return to IDLE.
  - Load write-back: wdata_o is the selected lane of bus_rdata_i, sign-extended (LB/LH) or zero-extended (LBU/LHU); LW takes the full word.
  - Store write-back: wreg_o=0.
  - Minimum memory-op latency is 2 cycles (issue cycle plus an ack in the first BUSY cycle).
- Timeout: the counter increments each BUSY cycle without ack. When it reaches TIMEOUT:
  - Abort: bus_req_o=0, exc_o=11, exc_addr_o=latched address, wb_valid_o=1 with wreg_o=0.
  - stall_o=0 in that cycle; return to IDLE.
  - If ack and timeout occur in the same cycle, the ack wins.
- valid_i low in IDLE: nothing issued, wb_valid_o=0, stall_o=0.
- An ack seen in IDLE is ignored.
- Back-to-back memory ops: the next op is issued from IDLE in the cycle after the ack, with no bubble beyond that.

Test Plan:
- LB at maddr=0x80000003, rdata=0x85xxxxxx → sel=1000, wdata_o=0xFFFFFF85. LBU at the same address → wdata_o=0x00000085. iram_conflict_o=1 while the request is outstanding.
- SH with reg2=0x1234ABCD at 0x80400002 → sel=1100, bus_wdata_o=0xABCD0000, we=1, iram_conflict_o=0, wreg_o=0 at the ack.
- LW at 0x80400001 → no bus_req_o, exc_o=01, exc_addr_o=0x80400001, stall_o=0. SW at 0x80400002 → exc_o=10.
- LW with ack delayed 3 cycles → stall_o high for 4 cycles, wdata_o=bus_rdata_i at the ack, wb_valid_o a single pulse. Two consecutive SB ops → second request issued one cycle after the first ack.
- No ack with TIMEOUT=16 → bus_req_o drops after 16 BUSY cycles, exc_o=11. Separate case: ack exactly on cycle 16 → normal completion.
- rst asserted in BUSY → all outputs 0 next edge; a later stray bus_ack_i produces no wb_valid_o.
